// File: rtl/exe_pkg.sv
// Package: exe_pkg
// Shared encodings and types for the execute stage.
//  - XLEN / IMM_W  : datapath and immediate widths
//  - opCode_t      : major op class carried on eOpCode
//  - HC_*          : sub-op codes, meaning depends on the op class
//  - BR_*          : branch condition codes carried on eBranch
//  - exeState_t    : execute-stage FSM states
//  - memBundle_t   : the registered m* bundle handed to the memory stage
//  - sext()        : immediate sign extension to XLEN
//  - bubble()      : m* bundle value for "no instruction"
package exe_pkg;

    localparam int XLEN  = 32;
    localparam int IMM_W = 20;

    typedef enum logic [1:0] {
        OP_ARITH = 2'b00,
        OP_LOGIC = 2'b01,
        OP_MEM   = 2'b10,
        OP_MUL   = 2'b11
    } opCode_t;

    // OP_ARITH sub-ops
    localparam logic [1:0] HC_ADD   = 2'b00;
    localparam logic [1:0] HC_SUB   = 2'b01;
    localparam logic [1:0] HC_AND   = 2'b10;
    localparam logic [1:0] HC_OR    = 2'b11;
    // OP_LOGIC sub-ops
    localparam logic [1:0] HC_XOR   = 2'b00;
    localparam logic [1:0] HC_SLL   = 2'b01;
    localparam logic [1:0] HC_SRL   = 2'b10;
    localparam logic [1:0] HC_SRA   = 2'b11;
    // OP_MUL sub-ops (2'b10 / 2'b11 are reserved)
    localparam logic [1:0] HC_MUL   = 2'b00;
    localparam logic [1:0] HC_MULHU = 2'b01;

    // Branch conditions; 3'b110 and 3'b111 behave as "none"
    localparam logic [2:0] BR_NONE   = 3'b000;
    localparam logic [2:0] BR_EQ     = 3'b001;
    localparam logic [2:0] BR_NE     = 3'b010;
    localparam logic [2:0] BR_LT     = 3'b011;
    localparam logic [2:0] BR_GE     = 3'b100;
    localparam logic [2:0] BR_ALWAYS = 3'b101;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } exeState_t;

    typedef struct packed {
        logic            nop;
        logic [XLEN-1:0] aluOut;
        logic [XLEN-1:0] stData;
        logic [3:0]      rd;
        logic            rdEnable;
        logic            ldEnable;
        logic            stEnable;
        logic            brTaken;
        logic [XLEN-1:0] brTarget;
    } memBundle_t;

    function automatic logic [XLEN-1:0] sext(input logic [IMM_W-1:0] imm);
        return {{(XLEN-IMM_W){imm[IMM_W-1]}}, imm};
    endfunction

    function automatic memBundle_t bubble();
        memBundle_t b;
        b     = '0;
        b.nop = 1'b1;
        return b;
    endfunction

endpackage

// File: rtl/seq_multiplier.sv
// Module: seq_multiplier
// Unsigned XLEN x XLEN multiplier, one shift-add step per clock.
//  clk    in   1        clock
//  rst    in   1        synchronous reset, active-low; aborts an operation
//  start  in   1        capture a/b and begin (ignored while busy)
//  a      in   XLEN     multiplicand
//  b      in   XLEN     multiplier
//  busy   out  1        operation in progress
//  done   out  1        high in the cycle of the final step
//  prod   out  2*XLEN   product; valid while done is high and is the value
//                       the final step commits, so a consumer can register
//                       it on the same edge that ends the operation
module seq_multiplier
    import exe_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [XLEN-1:0]   a,
    input  logic [XLEN-1:0]   b,
    output logic              busy,
    output logic              done,
    output logic [2*XLEN-1:0] prod
);

    localparam int CNT_W = $clog2(XLEN);

    logic [XLEN-1:0]   mcand;
    logic [2*XLEN-1:0] acc;      // {partial sum, remaining multiplier bits}
    logic [CNT_W-1:0]  count;
    logic [XLEN:0]     stepSum;  // one extra bit keeps the add carry
    logic [2*XLEN-1:0] accNext;

    // NOTE: every variable written in always_comb gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        stepSum = {1'b0, acc[2*XLEN-1:XLEN]};
        if (acc[0]) begin
            stepSum = stepSum + {1'b0, mcand};
        end
        // Shift the sum (with carry) down into the high half while the
        // consumed multiplier bit drops off the bottom.
        accNext = {stepSum, acc[XLEN-1:1]};
    end

    assign done = busy && (count == CNT_W'(XLEN-1));
    assign prod = accNext;

    // NOTE: state updates use non-blocking assignments so every register
    // samples its inputs from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        // NOTE: the datapath registers are reset along with the control bits;
        // they are few and it keeps the block free of X after reset.
        if (!rst) begin
            busy  <= 1'b0;
            count <= '0;
            mcand <= '0;
            acc   <= '0;
        end else if (busy) begin
            acc   <= accNext;
            count <= count + 1'b1;
            if (done) begin
                busy <= 1'b0;
            end
        end else if (start) begin
            mcand <= a;
            acc   <= {{XLEN{1'b0}}, b};
            count <= '0;
            busy  <= 1'b1;
        end
    end

endmodule

// File: rtl/execute_stage.sv
// Module: execute_stage
// Execute stage between the decode/execute latch (e* inputs) and the
// execute/memory register (m* outputs). Single-cycle ALU, shift, address and
// branch ops land in the m* register on the next edge; MUL/MULHU run on the
// iterative multiplier and hold ExStall high until the result is registered.
//  clk, rst                      clock; synchronous reset, active-low
//  eNOP                          bubble marker from the latch
//  eOpCode, eHardCode, eBranch   op class, sub-op, branch condition
//  eRd, eRdEnable                destination register and writeback request
//  eLdEnable, eAddrEnable        load / memory-access flags
//  eImmdEnable, eImmd            immediate select and value
//  ePC, eRsData, eRtData         PC, operand A, operand B register value
//  eRdData                       store data
//  ExStall                       multiply busy, stalls the upstream latch
//  mNOP .. mBrTarget             registered results for the memory stage
module execute_stage
    import exe_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             eNOP,
    input  logic [1:0]       eOpCode,
    input  logic [1:0]       eHardCode,
    input  logic [2:0]       eBranch,
    input  logic [3:0]       eRd,
    input  logic             eRdEnable,
    input  logic             eLdEnable,
    input  logic             eAddrEnable,
    input  logic             eImmdEnable,
    input  logic [IMM_W-1:0] eImmd,
    input  logic [XLEN-1:0]  ePC,
    input  logic [XLEN-1:0]  eRsData,
    input  logic [XLEN-1:0]  eRtData,
    input  logic [XLEN-1:0]  eRdData,
    output logic             ExStall,
    output logic             mNOP,
    output logic [XLEN-1:0]  mAluOut,
    output logic [XLEN-1:0]  mStData,
    output logic [3:0]       mRd,
    output logic             mRdEnable,
    output logic             mLdEnable,
    output logic             mStEnable,
    output logic             mBrTaken,
    output logic [XLEN-1:0]  mBrTarget
);

    exeState_t         state, stateNext;
    memBundle_t        mReg, singleResult, mulResult;

    logic [XLEN-1:0]   immExt, opB, aluResult;
    logic [4:0]        shamt;
    logic              brTaken;
    logic              isMulOp, mulStart, mulBusy, mulDone;
    logic [2*XLEN-1:0] mulProd;

    // Multiply bookkeeping captured when the operation starts; the latch
    // contents are not meaningful while the multiply runs.
    logic [1:0]        mulHc;
    logic [3:0]        mulRd;
    logic              mulRdEnable;

    assign immExt  = sext(eImmd);
    assign opB     = eImmdEnable ? immExt : eRtData;
    assign shamt   = opB[4:0];
    assign isMulOp = (eOpCode == OP_MUL) && ((eHardCode == HC_MUL) || (eHardCode == HC_MULHU));

    always_comb begin
        aluResult = '0;
        case (eOpCode)
            OP_ARITH: begin
                case (eHardCode)
                    HC_ADD:  aluResult = eRsData + opB;
                    HC_SUB:  aluResult = eRsData - opB;
                    HC_AND:  aluResult = eRsData & opB;
                    default: aluResult = eRsData | opB;
                endcase
            end
            OP_LOGIC: begin
                case (eHardCode)
                    HC_XOR:  aluResult = eRsData ^ opB;
                    HC_SLL:  aluResult = eRsData << shamt;
                    HC_SRL:  aluResult = eRsData >> shamt;
                    default: aluResult = $signed(eRsData) >>> shamt;
                endcase
            end
            OP_MEM:  aluResult = eRsData + immExt;
            default: aluResult = '0;  // reserved multiply sub-ops
        endcase
    end

    // Branch compare always uses the register operand, never the immediate.
    always_comb begin
        brTaken = 1'b0;
        case (eBranch)
            BR_EQ:     brTaken = (eRsData == eRtData);
            BR_NE:     brTaken = (eRsData != eRtData);
            BR_LT:     brTaken = ($signed(eRsData) <  $signed(eRtData));
            BR_GE:     brTaken = ($signed(eRsData) >= $signed(eRtData));
            BR_ALWAYS: brTaken = 1'b1;
            default:   brTaken = 1'b0;
        endcase
    end

    always_comb begin
        singleResult          = '0;
        singleResult.aluOut   = aluResult;
        singleResult.rd       = eRd;
        singleResult.rdEnable = eRdEnable;
        singleResult.brTaken  = brTaken;
        singleResult.brTarget = ePC + immExt;
        if (eOpCode == OP_MEM) begin
            singleResult.ldEnable = eLdEnable;
            singleResult.stEnable = eAddrEnable & ~eLdEnable;
            singleResult.stData   = eRdData;
        end
    end

    always_comb begin
        mulResult          = '0;
        mulResult.aluOut   = (mulHc == HC_MULHU) ? mulProd[2*XLEN-1:XLEN] : mulProd[XLEN-1:0];
        mulResult.rd       = mulRd;
        mulResult.rdEnable = mulRdEnable;
    end

    assign mulStart = (state == ST_IDLE) && !eNOP && isMulOp;

    seq_multiplier uMul (
        .clk   (clk),
        .rst   (rst),
        .start (mulStart),
        .a     (eRsData),
        .b     (opB),
        .busy  (mulBusy),
        .done  (mulDone),
        .prod  (mulProd)
    );

    always_comb begin
        stateNext = state;
        case (state)
            ST_IDLE: if (mulStart) stateNext = ST_MUL;
            // Leaving on !mulBusy as well guarantees the FSM can never sit in
            // MUL waiting for a multiplier that is not running.
            ST_MUL:  if (mulDone || !mulBusy) stateNext = ST_IDLE;
            default: stateNext = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= ST_IDLE;
            mReg        <= bubble();
            mulHc       <= '0;
            mulRd       <= '0;
            mulRdEnable <= 1'b0;
        end else begin
            state <= stateNext;
            if (state == ST_MUL) begin
                // m* keeps the bubble loaded at start until the product lands.
                if (mulDone) begin
                    mReg <= mulResult;
                end
            end else if (eNOP) begin
                mReg <= bubble();
            end else if (isMulOp) begin
                mReg        <= bubble();
                mulHc       <= eHardCode;
                mulRd       <= eRd;
                mulRdEnable <= eRdEnable;
            end else begin
                mReg <= singleResult;
            end
        end
    end

    // Decoded from state alone: no combinational path from e* inputs, so the
    // stall cannot form a loop through the upstream latch.
    assign ExStall   = (state == ST_MUL);

    assign mNOP      = mReg.nop;
    assign mAluOut   = mReg.aluOut;
    assign mStData   = mReg.stData;
    assign mRd       = mReg.rd;
    assign mRdEnable = mReg.rdEnable;
    assign mLdEnable = mReg.ldEnable;
    assign mStEnable = mReg.stEnable;
    assign mBrTaken  = mReg.brTaken;
    assign mBrTarget = mReg.brTarget;

endmodule

// File: tb/tb_execute_stage.sv
// Testbench: tb_execute_stage
// Directed steps followed by randomized instructions, each checked against a
// reference model computed from the instruction-level rules (plain arithmetic
// on the operands, product of two 64-bit zero-extended values for multiply).
module tb_execute_stage;

    logic        clk;
    logic        rst;
    logic        eNOP;
    logic [1:0]  eOpCode;
    logic [1:0]  eHardCode;
    logic [2:0]  eBranch;
    logic [3:0]  eRd;
    logic        eRdEnable;
    logic        eLdEnable;
    logic        eAddrEnable;
    logic        eImmdEnable;
    logic [19:0] eImmd;
    logic [31:0] ePC;
    logic [31:0] eRsData;
    logic [31:0] eRtData;
    logic [31:0] eRdData;
    logic        ExStall;
    logic        mNOP;
    logic [31:0] mAluOut;
    logic [31:0] mStData;
    logic [3:0]  mRd;
    logic        mRdEnable;
    logic        mLdEnable;
    logic        mStEnable;
    logic        mBrTaken;
    logic [31:0] mBrTarget;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        nop;
        logic [31:0] aluOut;
        logic [31:0] stData;
        logic [3:0]  rd;
        logic        rdEnable;
        logic        ldEnable;
        logic        stEnable;
        logic        brTaken;
        logic [31:0] brTarget;
    } expect_t;

    execute_stage dut (
        .clk         (clk),
        .rst         (rst),
        .eNOP        (eNOP),
        .eOpCode     (eOpCode),
        .eHardCode   (eHardCode),
        .eBranch     (eBranch),
        .eRd         (eRd),
        .eRdEnable   (eRdEnable),
        .eLdEnable   (eLdEnable),
        .eAddrEnable (eAddrEnable),
        .eImmdEnable (eImmdEnable),
        .eImmd       (eImmd),
        .ePC         (ePC),
        .eRsData     (eRsData),
        .eRtData     (eRtData),
        .eRdData     (eRdData),
        .ExStall     (ExStall),
        .mNOP        (mNOP),
        .mAluOut     (mAluOut),
        .mStData     (mStData),
        .mRd         (mRd),
        .mRdEnable   (mRdEnable),
        .mLdEnable   (mLdEnable),
        .mStEnable   (mStEnable),
        .mBrTaken    (mBrTaken),
        .mBrTarget   (mBrTarget)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic randomInputs();
        eNOP        = 1'($urandom);
        eOpCode     = 2'($urandom);
        eHardCode   = 2'($urandom);
        eBranch     = 3'($urandom);
        eRd         = 4'($urandom);
        eRdEnable   = 1'($urandom);
        eLdEnable   = 1'($urandom);
        eAddrEnable = 1'($urandom);
        eImmdEnable = 1'($urandom);
        eImmd       = 20'($urandom);
        ePC         = $urandom;
        eRsData     = $urandom;
        eRtData     = $urandom;
        eRdData     = $urandom;
    endtask

    task automatic driveOp(input logic [1:0] op, input logic [1:0] hc, input logic [2:0] br,
                           input logic immEn, input logic [19:0] imm, input logic [31:0] pc,
                           input logic [31:0] a, input logic [31:0] rt);
        randomInputs();
        eNOP        = 1'b0;
        eOpCode     = op;
        eHardCode   = hc;
        eBranch     = br;
        eImmdEnable = immEn;
        eImmd       = imm;
        ePC         = pc;
        eRsData     = a;
        eRtData     = rt;
    endtask

    // Immediate as a two's-complement 20-bit number reduced mod 2^32.
    function automatic logic [31:0] immValue();
        if (eImmd[19]) return 32'(eImmd) - 32'h0010_0000;
        return 32'(eImmd);
    endfunction

    function automatic logic [31:0] operandB();
        return eImmdEnable ? immValue() : eRtData;
    endfunction

    function automatic expect_t expectFor();
        expect_t     x;
        logic [31:0] a, b;
        int          sh;
        int          sa, srt;
        x = '0;
        if (eNOP) begin
            x.nop = 1'b1;
            return x;
        end
        a  = eRsData;
        b  = operandB();
        sh = int'(b % 32);
        case ({eOpCode, eHardCode})
            4'b0000: x.aluOut = a + b;
            4'b0001: x.aluOut = a - b;
            4'b0010: x.aluOut = a & b;
            4'b0011: x.aluOut = a | b;
            4'b0100: x.aluOut = a ^ b;
            4'b0101: x.aluOut = a << sh;
            4'b0110: x.aluOut = a >> sh;
            4'b0111: x.aluOut = $signed(a) >>> sh;
            4'b1000, 4'b1001, 4'b1010, 4'b1011: x.aluOut = a + immValue();
            default: x.aluOut = 32'h0;
        endcase
        x.rd       = eRd;
        x.rdEnable = eRdEnable;
        if (eOpCode == 2'b10) begin
            x.ldEnable = eLdEnable;
            x.stEnable = eAddrEnable && !eLdEnable;
            x.stData   = eRdData;
        end
        sa  = int'(eRsData);
        srt = int'(eRtData);
        case (eBranch)
            3'd1:    x.brTaken = (eRsData == eRtData);
            3'd2:    x.brTaken = (eRsData != eRtData);
            3'd3:    x.brTaken = (sa < srt);
            3'd4:    x.brTaken = (sa >= srt);
            3'd5:    x.brTaken = 1'b1;
            default: x.brTaken = 1'b0;
        endcase
        x.brTarget = ePC + immValue();
        return x;
    endfunction

    task automatic compareAll(input string tag, input expect_t x);
        check({tag, ".mNOP"},      64'(mNOP),      64'(x.nop));
        check({tag, ".mAluOut"},   64'(mAluOut),   64'(x.aluOut));
        check({tag, ".mStData"},   64'(mStData),   64'(x.stData));
        check({tag, ".mRd"},       64'(mRd),       64'(x.rd));
        check({tag, ".mRdEnable"}, 64'(mRdEnable), 64'(x.rdEnable));
        check({tag, ".mLdEnable"}, 64'(mLdEnable), 64'(x.ldEnable));
        check({tag, ".mStEnable"}, 64'(mStEnable), 64'(x.stEnable));
        check({tag, ".mBrTaken"},  64'(mBrTaken),  64'(x.brTaken));
        check({tag, ".mBrTarget"}, 64'(mBrTarget), 64'(x.brTarget));
        check({tag, ".ExStall"},   64'(ExStall),   64'h0);
    endtask

    task automatic runSingle(input string tag);
        expect_t x;
        x = expectFor();
        tick();
        compareAll(tag, x);
    endtask

    // Multiply already driven on e*: checks start bubble, the stall length
    // and the registered product.
    task automatic runMul(input string tag);
        logic [63:0] p;
        logic [31:0] want;
        logic [3:0]  rd;
        logic        rdEn;
        int          n;
        p    = {32'h0, eRsData} * {32'h0, operandB()};
        want = (eHardCode == 2'b01) ? p[63:32] : p[31:0];
        rd   = eRd;
        rdEn = eRdEnable;
        tick();
        check({tag, ".startBubble"}, 64'(mNOP), 64'h1);
        n = (ExStall === 1'b1) ? 1 : 0;
        randomInputs();
        eNOP = 1'b1;
        while (ExStall === 1'b1 && n < 100) begin
            tick();
            if (ExStall === 1'b1) n++;
        end
        check({tag, ".stallCycles"}, 64'(n),         64'd32);
        check({tag, ".mNOP"},        64'(mNOP),      64'h0);
        check({tag, ".mAluOut"},     64'(mAluOut),   64'(want));
        check({tag, ".mRd"},         64'(mRd),       64'(rd));
        check({tag, ".mRdEnable"},   64'(mRdEnable), 64'(rdEn));
        check({tag, ".mBrTaken"},    64'(mBrTaken),  64'h0);
    endtask

    initial begin
        logic sawResult;

        // Reset with live random instructions on the inputs.
        rst = 1'b0;
        randomInputs();
        eNOP = 1'b0;
        tick();
        randomInputs();
        eNOP = 1'b0;
        tick();
        compareAll("reset", '{nop: 1'b1, default: '0});
        rst = 1'b1;

        // ADD with sign-extended immediate -1.
        driveOp(2'b00, 2'b00, 3'd0, 1'b1, 20'hFFFFF, 32'h0, 32'd5, $urandom);
        eRdEnable = 1'b1;
        eRd       = 4'd3;
        runSingle("addImm");
        check("addImm.const", 64'(mAluOut), 64'd4);

        // Shifts: arithmetic right, and shift amount taken from B[4:0].
        driveOp(2'b01, 2'b11, 3'd0, 1'b0, 20'h0, 32'h0, 32'h8000_0000, 32'd4);
        runSingle("sra");
        check("sra.const", 64'(mAluOut), 64'hF800_0000);
        driveOp(2'b01, 2'b01, 3'd0, 1'b0, 20'h0, 32'h0, 32'h3, 32'd33);
        runSingle("sll33");
        check("sll33.const", 64'(mAluOut), 64'h6);

        // Signed less-than branch, taken then one-cycle pulse, then not taken.
        driveOp(2'b00, 2'b00, 3'd3, 1'b0, 20'h10, 32'h100, 32'hFFFF_FFFF, 32'h1);
        runSingle("bltTaken");
        check("bltTaken.pulse",  64'(mBrTaken),  64'h1);
        check("bltTaken.target", 64'(mBrTarget), 64'h110);
        randomInputs();
        eNOP = 1'b1;
        runSingle("bltPulseEnd");
        driveOp(2'b00, 2'b00, 3'd3, 1'b0, 20'h10, 32'h100, 32'h1, 32'hFFFF_FFFF);
        runSingle("bltNotTaken");

        // Memory op: address and store request.
        driveOp(2'b10, 2'b00, 3'd0, 1'b0, 20'h80000, 32'h0, 32'h1000_0000, $urandom);
        eLdEnable   = 1'b0;
        eAddrEnable = 1'b1;
        runSingle("store");

        // Reserved multiply sub-op is single-cycle with a zero result.
        driveOp(2'b11, 2'b10, 3'd0, 1'b0, 20'h0, 32'h0, $urandom, $urandom);
        runSingle("mulReserved");

        // Multiply low and high halves.
        driveOp(2'b11, 2'b00, 3'd0, 1'b0, 20'h0, 32'h0, 32'hFFFF_FFFF, 32'd2);
        runMul("mul");
        check("mul.const", 64'(mAluOut), 64'hFFFF_FFFE);
        driveOp(2'b11, 2'b01, 3'd0, 1'b0, 20'h0, 32'h0, 32'hFFFF_FFFF, 32'd2);
        runMul("mulhu");
        check("mulhu.const", 64'(mAluOut), 64'h1);

        // Reset in the middle of a multiply aborts it.
        driveOp(2'b11, 2'b00, 3'd0, 1'b0, 20'h0, 32'h0, $urandom, $urandom);
        tick();
        randomInputs();
        eNOP = 1'b1;
        repeat (10) tick();
        rst = 1'b0;
        tick();
        check("rstMul.ExStall", 64'(ExStall), 64'h0);
        check("rstMul.mNOP",    64'(mNOP),    64'h1);
        check("rstMul.mAluOut", 64'(mAluOut), 64'h0);
        rst = 1'b1;
        sawResult = 1'b0;
        repeat (40) begin
            tick();
            if (mNOP !== 1'b1 || ExStall !== 1'b0) sawResult = 1'b1;
        end
        check("rstMul.noResult", 64'(sawResult), 64'h0);
        driveOp(2'b00, 2'b00, 3'd0, 1'b0, 20'h0, 32'h0, 32'd1234, 32'd4321);
        runSingle("rstMul.add");

        // Randomized instruction stream.
        for (int i = 0; i < 150; i++) begin
            randomInputs();
            eNOP = ($urandom_range(0, 7) == 0);
            if (!eNOP && eOpCode == 2'b11 && !eHardCode[1]) begin
                runMul($sformatf("rnd%0d.mul", i));
            end else begin
                runSingle($sformatf("rnd%0d", i));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
